// File: rtl/rmii_byte_serializer.sv
// RMII transmit serializer: prepends preamble/SFD, shifts frame bytes out LSB dibit
// first at 100 or 10 Mb/s on the 50 MHz reference clock, and enforces the inter-frame gap.
module rmii_byte_serializer #(
    parameter logic [1:0]  SPEED_CODE_100_MEGABIT = 2'd1,
    parameter logic [1:0]  SPEED_CODE_10_MEGABIT  = 2'd0,
    parameter int unsigned INTER_FRAME_GAP_BYTES  = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] speed_code,
    input  logic [8:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] rmii_data,
    output logic       rmii_data_enable,
    output logic       underrun,
    output logic       busy
);
    // state      | meaning
    // S_IDLE     | line idle, waiting for data_valid
    // S_PREAMBLE | 28 dibits of 01
    // S_SFD      | 0xD5 shifted out; its last clock is the first load point
    // S_DATA     | frame byte shifting; load point at the end of a non-last byte
    // S_GAP      | line idle, busy held until the gap expires
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_GAP
    } state_t;

    localparam int unsigned PREAMBLE_DIBITS = 28;
    localparam int unsigned GAP_DIBITS      = 4 * INTER_FRAME_GAP_BYTES;
    localparam int unsigned SEQ_MAX         = (GAP_DIBITS > PREAMBLE_DIBITS) ? GAP_DIBITS : PREAMBLE_DIBITS;
    localparam int unsigned SEQ_W           = $clog2(SEQ_MAX);
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;

    state_t           state;
    logic             speed_10;
    logic             last_byte;
    logic [3:0]       period_cnt;
    logic [1:0]       dibit_idx;
    logic [SEQ_W-1:0] seq_cnt;
    logic [7:0]       shift_reg;

    logic       dibit_end;
    logic       byte_end;
    logic       gap_done;
    logic       speed_10_next;
    logic [3:0] period_load;

    assign dibit_end     = (period_cnt == 4'd0);
    assign byte_end      = dibit_end && (dibit_idx == 2'd3);
    assign period_load   = speed_10 ? 4'd9 : 4'd0;
    assign speed_10_next = (speed_code == SPEED_CODE_10_MEGABIT) && (speed_code != SPEED_CODE_100_MEGABIT);
    assign data_ready    = byte_end && ((state == S_SFD) || ((state == S_DATA) && !last_byte));

    // The S_IDLE clock that follows S_GAP is the final clock of the gap, so S_GAP leaves one clock early.
    assign gap_done = speed_10 ? ((seq_cnt == '0) && (period_cnt == 4'd1))
                               : (seq_cnt == SEQ_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            speed_10         <= 1'b0;
            last_byte        <= 1'b0;
            period_cnt       <= 4'd0;
            dibit_idx        <= 2'd0;
            seq_cnt          <= '0;
            shift_reg        <= 8'd0;
            rmii_data        <= 2'b00;
            rmii_data_enable <= 1'b0;
            underrun         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            underrun   <= 1'b0;
            period_cnt <= dibit_end ? period_load : period_cnt - 4'd1;
            case (state)
                S_IDLE: begin
                    if (data_valid) begin
                        state            <= S_PREAMBLE;
                        speed_10         <= speed_10_next;
                        period_cnt       <= speed_10_next ? 4'd9 : 4'd0;
                        seq_cnt          <= SEQ_W'(PREAMBLE_DIBITS - 1);
                        rmii_data        <= 2'b01;
                        rmii_data_enable <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    if (dibit_end) begin
                        if (seq_cnt == '0) begin
                            state     <= S_SFD;
                            rmii_data <= SFD_BYTE[1:0];
                            shift_reg <= {2'b00, SFD_BYTE[7:2]};
                            dibit_idx <= 2'd0;
                        end else begin
                            seq_cnt <= seq_cnt - SEQ_W'(1);
                        end
                    end
                end
                S_SFD, S_DATA: begin
                    if (byte_end) begin
                        if ((state == S_DATA) && last_byte) begin
                            state            <= S_GAP;
                            rmii_data        <= 2'b00;
                            rmii_data_enable <= 1'b0;
                            seq_cnt          <= SEQ_W'(GAP_DIBITS - 1);
                        end else if (data_valid) begin
                            state     <= S_DATA;
                            rmii_data <= data[1:0];
                            shift_reg <= {2'b00, data[7:2]};
                            last_byte <= data[8];
                            dibit_idx <= 2'd0;
                        end else begin
                            state            <= S_GAP;
                            rmii_data        <= 2'b00;
                            rmii_data_enable <= 1'b0;
                            underrun         <= 1'b1;
                            seq_cnt          <= SEQ_W'(GAP_DIBITS - 1);
                        end
                    end else if (dibit_end) begin
                        rmii_data <= shift_reg[1:0];
                        shift_reg <= {2'b00, shift_reg[7:2]};
                        dibit_idx <= dibit_idx + 2'd1;
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (dibit_end) begin
                        seq_cnt <= seq_cnt - SEQ_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_byte_serializer.sv
// Bench for rmii_byte_serializer: a frame-level line model predicts every output cycle,
// plus literal frame measurements for the main timing points.
module tb_rmii_byte_serializer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] speed_code = 2'd1;
    logic [8:0] data = 9'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [1:0] rmii_data;
    logic       rmii_data_enable;
    logic       underrun;
    logic       busy;

    rmii_byte_serializer dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .speed_code       (speed_code),
        .data             (data),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .rmii_data        (rmii_data),
        .rmii_data_enable (rmii_data_enable),
        .underrun         (underrun),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       en;
        logic [1:0] d;
        logic       rdy;
        logic       ur;
        logic       bsy;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] feed_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    int         cyc = 0;
    int         en_len = 0;
    int         low_run = 0;
    int         low_between = 0;
    int         busy_fall_cyc = 0;
    int         rise_after_busy = 0;
    int         ur_count = 0;
    logic [7:0] hist = 8'd0;
    logic       prev_en = 1'b0;
    logic       prev_busy = 1'b0;
    int         ready_pos[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected line activity for one frame: every dibit held p clocks, gap, then one idle clock.
    task automatic build_frame(input int n, input logic [8:0] b0, input logic [8:0] b1, input int p);
        logic [1:0] dq[$];
        bit         rq[$];
        bit         ur;
        logic [8:0] v;
        exp_t       e;
        ur = 1'b1;
        for (int i = 0; i < 31; i++) begin
            dq.push_back(2'b01);
            rq.push_back(1'b0);
        end
        dq.push_back(2'b11);
        rq.push_back(1'b1);
        for (int i = 0; i < n; i++) begin
            v = (i == 0) ? b0 : b1;
            for (int k = 0; k < 4; k++) begin
                dq.push_back(v[2*k +: 2]);
                rq.push_back((k == 3) && !v[8]);
            end
            if (v[8]) begin
                ur = 1'b0;
                break;
            end
        end
        foreach (dq[j]) begin
            for (int c = 0; c < p; c++) begin
                e.en  = 1'b1;
                e.d   = dq[j];
                e.rdy = rq[j] && (c == p - 1);
                e.ur  = 1'b0;
                e.bsy = 1'b1;
                exp_q.push_back(e);
            end
        end
        for (int c = 0; c < 48 * p - 1; c++) begin
            e     = '0;
            e.ur  = ur && (c == 0);
            e.bsy = 1'b1;
            exp_q.push_back(e);
        end
        exp_q.push_back(exp_t'(0));
    endtask

    task automatic start_frame(input int n, input logic [8:0] b0, input logic [8:0] b1, input int p);
        feed_q.push_back(b0);
        if (n > 1) feed_q.push_back(b1);
        build_frame(n, b0, b1, p);
    endtask

    task automatic drive_inputs();
        if (feed_q.size() != 0) begin
            data_valid = 1'b1;
            data       = feed_q[0];
        end else begin
            data_valid = 1'b0;
        end
    endtask

    task automatic track();
        cyc++;
        if (rmii_data_enable) begin
            if (!prev_en) begin
                en_len          = 0;
                ready_pos.delete();
                low_between     = low_run;
                rise_after_busy = cyc - busy_fall_cyc;
            end
            en_len++;
            hist = {hist[5:0], rmii_data};
            if (data_ready) ready_pos.push_back(en_len);
            low_run = 0;
        end else begin
            low_run++;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (underrun) ur_count++;
        prev_en   = rmii_data_enable;
        prev_busy = busy;
    endtask

    task automatic step();
        bit   took;
        exp_t e;
        took = data_ready && data_valid;
        @(posedge clock);
        #1;
        if (took && feed_q.size() != 0) void'(feed_q.pop_front());
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check($sformatf("outputs{en,d,rdy,ur,busy} cycle %0d", cyc),
              int'({rmii_data_enable, rmii_data, data_ready, underrun, busy}), int'(e));
        track();
        drive_inputs();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        drive_inputs();
        while (exp_q.size() != 0 && guard < 5000) begin
            step();
            guard++;
        end
        check("drain within budget", int'(guard < 5000), 1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("reset outputs", int'({rmii_data_enable, rmii_data, data_ready, underrun, busy}), 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();

        // 100 Mb/s single last byte 0xA6
        speed_code = 2'd1;
        start_frame(1, 9'h1A6, 9'h000, 1);
        check("model length 1 byte 100M", exp_q.size(), 84);
        drain();
        check("enable clocks 1 byte 100M", en_len, 36);
        check("ready pulse count 1 byte", ready_pos.size(), 1);
        check("ready pulse position", ready_pos[0], 32);
        check("data dibits 0xA6", hist, 8'h9A);
        check("busy low after gap", busy, 0);

        // 10 Mb/s two bytes
        speed_code = 2'd0;
        start_frame(2, 9'h055, 9'h1FF, 10);
        drain();
        check("enable clocks 2 bytes 10M", en_len, 400);
        check("ready pulse count 2 bytes", ready_pos.size(), 2);
        check("first ready 10M", ready_pos[0], 320);
        check("ready spacing 10M", ready_pos[1] - ready_pos[0], 40);
        check("data dibits 0xFF", hist, 8'hFF);

        // underrun after a non-last 0x34, unlisted speed code runs at 100 Mb/s
        speed_code = 2'd2;
        ur_count   = 0;
        start_frame(2, 9'h012, 9'h034, 1);
        drain();
        check("underrun pulses", ur_count, 1);
        // 0x34 LSB dibit first: 00,01,11,00
        check("last dibits before underrun", hist, 8'h1C);
        check("enable clocks underrun", en_len, 40);
        check("ready pulses underrun", ready_pos.size(), 3);

        // back-to-back frames with data_valid held high
        speed_code = 2'd1;
        start_frame(1, 9'h1A6, 9'h000, 1);
        start_frame(1, 9'h1C3, 9'h000, 1);
        drain();
        check("idle clocks between frames", low_between, 48);
        check("restart after busy fall", rise_after_busy, 1);
        check("enable clocks second frame", en_len, 36);

        // reset during the 10th preamble dibit
        start_frame(1, 9'h1A6, 9'h000, 1);
        drive_inputs();
        repeat (10) step();
        check("enable clocks before reset", en_len, 10);
        #2 reset_n = 1'b0;
        #1;
        check("async reset mid-frame", int'({rmii_data_enable, rmii_data, data_ready, underrun, busy}), 0);
        exp_q.delete();
        feed_q.delete();
        drive_inputs();
        repeat (3) step();
        reset_n = 1'b1;
        start_frame(1, 9'h1A6, 9'h000, 1);
        drain();
        check("enable clocks after reset", en_len, 36);
        check("ready position after reset", ready_pos[0], 32);

        // speed change mid-frame takes effect on the next frame only
        speed_code = 2'd1;
        start_frame(1, 9'h1A6, 9'h000, 1);
        drive_inputs();
        repeat (20) step();
        speed_code = 2'd0;
        drain();
        check("enable clocks switched frame", en_len, 36);
        start_frame(1, 9'h15A, 9'h000, 10);
        drain();
        check("enable clocks next frame 10M", en_len, 360);
        check("ready position next frame 10M", ready_pos[0], 320);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
